// File: rtl/alu_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for alu_pipe.
// slave is the ALU side; master is the issue/writeback side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, y, zero, carry, overflow, negative, busy
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, y, zero, carry, overflow, negative, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, a persistent carry flag for ADDC
// and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
    OP_SRA, OP_SLT, OP_SLTU, OP_MOVA, OP_MOVB, OP_ADDC, OP_MUL, OP_RSVD
  } op_e;

  state_e             state, state_nxt;
  op_e                op;
  logic [SHW-1:0]     cnt;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt, prod;
  logic [WIDTH-1:0]   mplier;
  logic               can_load, load, load_mul, start_mul, in_ready_c, busy_c;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res, y_nxt, y_q;
  logic               c_res, v_res, c_nxt, v_nxt;
  logic               cflag, upd_cflag;
  logic               out_valid_q, zero_q, carry_q, overflow_q, negative_q;

  assign op       = op_e'(bus.opcode);
  assign sh       = bus.b[SHW-1:0];
  assign can_load = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    load       = 1'b0;
    load_mul   = 1'b0;
    start_mul  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_c = can_load;
        if (bus.in_valid && can_load) begin
          if (op == OP_MUL) begin
            start_mul = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        busy_c = 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          if (can_load) begin
            load      = 1'b1;
            load_mul  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (can_load) begin
          load      = 1'b1;
          load_mul  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The final step's sum is the product; HOLD keeps it parked in acc.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign prod    = (state == ST_HOLD) ? acc : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplier <= bus.b;
    end else if (state == ST_MUL) begin
      cnt    <= cnt + SHW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, (op == OP_ADDC) && cflag};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        res   = sum[WIDTH-1:0];
        c_res = sum[WIDTH];
        v_res = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        c_res = diff[WIDTH];
        v_res = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_XOR:  res = bus.a ^ bus.b;
      OP_NOR:  res = ~(bus.a | bus.b);
      OP_SLL:  res = bus.a << sh;
      OP_SRL:  res = bus.a >> sh;
      OP_SRA:  res = WIDTH'($signed(bus.a) >>> sh);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_MOVA: res = bus.a;
      OP_MOVB: res = bus.b;
      default: res = '0;
    endcase
  end

  always_comb begin
    y_nxt = res;
    c_nxt = c_res;
    v_nxt = v_res;
    if (load_mul) begin
      y_nxt = prod[WIDTH-1:0];
      c_nxt = 1'b0;
      v_nxt = |prod[2*WIDTH-1:WIDTH];
    end
  end

  assign upd_cflag = load && !load_mul && (op == OP_ADD || op == OP_SUB || op == OP_ADDC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      cflag       <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        y_q         <= y_nxt;
        zero_q      <= (y_nxt == '0);
        carry_q     <= c_nxt;
        overflow_q  <= v_nxt;
        negative_q  <= y_nxt[WIDTH-1];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (upd_cflag) cflag <= c_res;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.negative  = negative_q;

endmodule
